// File: rtl/mx_pkg.sv
// rtl/mx_pkg.sv - shared constants and FSM state type for the MXINT block-sum pipe
package mx_pkg;

    localparam int SCALE_WIDTH   = 8;
    localparam int FLOAT32_WIDTH = 32;
    localparam int FP32_BIAS     = 127;

    localparam logic [FLOAT32_WIDTH-1:0] FP32_POS_INF = 32'h7F80_0000;
    localparam logic [FLOAT32_WIDTH-1:0] FP32_QNAN    = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        ACC  = 2'd0,
        NORM = 2'd1,
        HOLD = 2'd2
    } mx_state_e;

endpackage

// File: rtl/mx_int_to_fp32.sv
// rtl/mx_int_to_fp32.sv - exact signed integer block sum plus E8M0 scale to float32 (MX_SUM_SCALE_NAN_EN: scale 0xFF gives qNaN)
module mx_int_to_fp32
    import mx_pkg::*;
#(
    parameter int ACC_W      = 13,
    parameter int ELEM_WIDTH = 8
) (
    input  logic signed [ACC_W-1:0]         acc,
    input  logic [SCALE_WIDTH-1:0]          scale,
    output logic [FLOAT32_WIDTH-1:0]        fp32,
    output logic                            overflow
);

    logic             sign;
    logic [ACC_W-1:0] mag;
    logic [4:0]       p;
    logic [10:0]      exp_s;
    logic [22:0]      mant;

    always_comb begin
        sign = acc[ACC_W-1];
        mag  = sign ? (~acc + 1'b1) : acc;
        p    = 5'd0;
        for (int i = 0; i < ACC_W; i++) begin
            if (mag[i]) p = 5'(i);
        end
        // E8M0 and float32 share bias 127, so only the element fraction shift remains
        exp_s = 11'(p) + 11'(scale) - 11'(ELEM_WIDTH - 2);
        // leading one lands on bit 23 and drops out; the rest is the exact mantissa
        mant  = 23'({mag, 23'd0} >> p);

        fp32     = {sign, exp_s[7:0], mant};
        overflow = 1'b0;
        if (acc == '0) begin
            fp32 = '0;
        end else if ($signed(exp_s) >= 11'sd255) begin
            fp32     = FP32_POS_INF | {sign, 31'd0};
            overflow = 1'b1;
        end else if ($signed(exp_s) <= 11'sd0) begin
            fp32 = {sign, 31'd0};
        end
`ifdef MX_SUM_SCALE_NAN_EN
        if (scale == 8'hFF) begin
            fp32     = FP32_QNAN;
            overflow = 1'b0;
        end
`else
`endif
    end

endmodule

// File: rtl/mxint_block_sum_pipe.sv
// rtl/mxint_block_sum_pipe.sv - streaming MX integer block sum to float32 (MX_SUM_SCALE_NAN_EN selects scale-0xFF NaN handling)
module mxint_block_sum_pipe
    import mx_pkg::*;
#(
    parameter int BLOCK_SIZE = 32,
    parameter int ELEM_WIDTH = 8,
    parameter int LANES      = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [SCALE_WIDTH-1:0]        in_scale,
    input  logic [LANES*ELEM_WIDTH-1:0]   in_elems,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [FLOAT32_WIDTH-1:0]      out_float32,
    output logic                          out_overflow
);

    localparam int BEATS = BLOCK_SIZE / LANES;
    localparam int ACC_W = ELEM_WIDTH + $clog2(BLOCK_SIZE);
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    generate
        if (ACC_W > 24 || (BLOCK_SIZE % LANES) != 0) begin : g_bad_cfg
            $error("mxint_block_sum_pipe: ACC_W must be <= 24 and LANES must divide BLOCK_SIZE");
        end
    endgenerate

    mx_state_e                  state;
    logic [CNT_W-1:0]           beat_cnt;
    logic signed [ACC_W-1:0]    acc;
    logic [SCALE_WIDTH-1:0]     scale;
    logic signed [ACC_W-1:0]    beat_sum;
    logic [FLOAT32_WIDTH-1:0]   conv_f;
    logic                       conv_ovf;

    assign in_ready = rst_n && (state == ACC);

    always_comb begin
        beat_sum = '0;
        for (int l = 0; l < LANES; l++) begin
            beat_sum = beat_sum + ACC_W'($signed(in_elems[l*ELEM_WIDTH +: ELEM_WIDTH]));
        end
    end

    mx_int_to_fp32 #(
        .ACC_W      (ACC_W),
        .ELEM_WIDTH (ELEM_WIDTH)
    ) u_norm (
        .acc      (acc),
        .scale    (scale),
        .fp32     (conv_f),
        .overflow (conv_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ACC;
            beat_cnt     <= '0;
            acc          <= '0;
            scale        <= '0;
            out_valid    <= 1'b0;
            out_float32  <= '0;
            out_overflow <= 1'b0;
        end else begin
            case (state)
                ACC: begin
                    if (in_valid) begin
                        // first beat restarts the sum so no explicit clear is needed between blocks
                        if (beat_cnt == '0) begin
                            acc   <= beat_sum;
                            scale <= in_scale;
                        end else begin
                            acc <= acc + beat_sum;
                        end
                        if (beat_cnt == CNT_W'(BEATS - 1)) begin
                            beat_cnt <= '0;
                            state    <= NORM;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                NORM: begin
                    out_float32  <= conv_f;
                    out_overflow <= conv_ovf;
                    out_valid    <= 1'b1;
                    state        <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ACC;
                    end
                end
                default: state <= ACC;
            endcase
        end
    end

endmodule

// File: tb/tb_mxint_block_sum_pipe.sv
// tb/tb_mxint_block_sum_pipe.sv - scoreboard bench for mxint_block_sum_pipe (MX_SUM_SCALE_NAN_EN aware)
module tb_mxint_block_sum_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_scale = 8'd0;
    logic [63:0] in_elems = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_float32;
    logic        out_overflow;

    typedef struct packed {
        logic [31:0] f;
        logic        o;
    } exp_t;

    exp_t              sb[$];
    logic signed [7:0] blk [32];
    int                passed = 0;
    int                total = 0;

    always #5 clk = ~clk;

    mxint_block_sum_pipe #(
        .BLOCK_SIZE (32),
        .ELEM_WIDTH (8),
        .LANES      (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_scale     (in_scale),
        .in_elems     (in_elems),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_float32  (out_float32),
        .out_overflow (out_overflow)
    );

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endfunction

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                total++;
                $display("FAIL unexpected_result: got %h with no expected entry", out_float32);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result_float32", out_float32, e.f);
                chk("result_overflow", {31'd0, out_overflow}, {31'd0, e.o});
            end
        end
    end

    task automatic fill_all(input logic signed [7:0] v);
        for (int i = 0; i < 32; i++) blk[i] = v;
    endtask

    task automatic send_block(input logic [7:0] sc, input int nbeats, input int gap,
                              input logic [31:0] ef, input logic eo, input bit push, input bit lat);
        for (int b = 0; b < nbeats; b++) begin
            for (int g = 0; g < gap; g++) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            // scale on later beats is junk and must be ignored
            in_scale = (b == 0) ? sc : 8'h5A;
            for (int l = 0; l < 8; l++) in_elems[l*8 +: 8] = blk[b*8 + l];
            begin
                int t;
                t = 0;
                @(negedge clk);
                while (!in_ready && t < 200) begin
                    t++;
                    @(negedge clk);
                end
                if (!in_ready) begin
                    total++;
                    $display("FAIL beat_accept_timeout: in_ready stayed %b, required 1", in_ready);
                    in_valid = 1'b0;
                    return;
                end
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (push && nbeats == 4) sb.push_back({ef, eo});
        if (lat) begin
            @(negedge clk);
            chk("latency_norm_cycle", {31'd0, out_valid}, 32'd0);
            @(negedge clk);
            chk("latency_hold_cycle", {31'd0, out_valid}, 32'd1);
        end
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0) begin
            total++;
            $display("FAIL drain_timeout: %0d results pending, required 0", sb.size());
            sb.delete();
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] ovf_f;
        logic        ovf_o;

        // reset state
        repeat (2) @(negedge clk);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd0);
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_out_float32", out_float32, 32'd0);
        chk("reset_out_overflow", {31'd0, out_overflow}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        out_ready = 1'b1;

        fill_all(8'sd64);
        send_block(8'd127, 4, 0, 32'h4200_0000, 1'b0, 1'b1, 1'b1);
        wait_drain();

        fill_all(-8'sd128);
        send_block(8'd127, 4, 0, 32'hC280_0000, 1'b0, 1'b1, 1'b0);
        wait_drain();

        for (int i = 0; i < 32; i++) blk[i] = (i % 2 == 0) ? 8'sd64 : -8'sd64;
        send_block(8'd200, 4, 2, 32'h0000_0000, 1'b0, 1'b1, 1'b0);
        wait_drain();

        fill_all(8'sd127);
        send_block(8'd254, 4, 0, 32'h7F80_0000, 1'b1, 1'b1, 1'b0);
        wait_drain();

        fill_all(8'sd0);
        blk[0] = 8'sd1;
        send_block(8'd0, 4, 1, 32'h0000_0000, 1'b0, 1'b1, 1'b0);
        wait_drain();

        fill_all(8'sd0);
        blk[5] = 8'sd3;
        send_block(8'd127, 4, 0, 32'h3D40_0000, 1'b0, 1'b1, 1'b0);
        wait_drain();

        fill_all(8'sd0);
        blk[31] = -8'sd1;
        send_block(8'd127, 4, 0, 32'hBC80_0000, 1'b0, 1'b1, 1'b0);
        wait_drain();

        // backpressure: first result must hold while a second block waits
        out_ready = 1'b0;
        fill_all(8'sd64);
        send_block(8'd127, 4, 0, 32'h4200_0000, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        fork
            begin
                fill_all(-8'sd128);
                send_block(8'd127, 4, 0, 32'hC280_0000, 1'b0, 1'b1, 1'b0);
            end
            begin
                for (int c = 0; c < 10; c++) begin
                    @(negedge clk);
                    chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
                    chk("stall_out_float32", out_float32, 32'h4200_0000);
                    chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        wait_drain();

        // reset mid-block discards the partial sum
        fill_all(8'sd127);
        send_block(8'd127, 2, 0, 32'h0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midblock_reset_in_ready", {31'd0, in_ready}, 32'd0);
        chk("midblock_reset_out_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) blk[i] = 8'(i - 16);
        send_block(8'd127, 4, 0, 32'hBE80_0000, 1'b0, 1'b1, 1'b0);
        wait_drain();

        // reset during HOLD drops the pending result
        out_ready = 1'b0;
        fill_all(8'sd64);
        send_block(8'd127, 4, 0, 32'h0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        chk("hold_before_reset_valid", {31'd0, out_valid}, 32'd1);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk("hold_reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("hold_reset_out_float32", out_float32, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;

`ifdef MX_SUM_SCALE_NAN_EN
        ovf_f = 32'h7FC0_0000;
        ovf_o = 1'b0;
`else
        ovf_f = 32'hFF80_0000;
        ovf_o = 1'b1;
`endif
        fill_all(-8'sd5);
        send_block(8'hFF, 4, 0, ovf_f, ovf_o, 1'b1, 1'b0);
        wait_drain();

        fill_all(8'sd64);
        send_block(8'd127, 4, 0, 32'h4200_0000, 1'b0, 1'b1, 1'b0);
        wait_drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
